// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: data-bus request/response types and memory-stage states
package mem_access_unit_pkg;
  typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2} msize_t;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} mem_state_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: shifts bus data to the accessed byte lane and sign/zero-extends
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addr,
  input  msize_t      size,
  input  logic        is_unsigned,
  output logic [31:0] result
);
  logic [1:0]  ofs;
  logic [31:0] b;
  assign ofs = size == MSIZE2 ? {addr[1], 1'b0} : addr;
  assign b = data >> {ofs, 3'b000};
  assign result = size == MSIZE1 ? {{24{b[7] & ~is_unsigned}}, b[7:0]} :
                  size == MSIZE2 ? {{16{b[15] & ~is_unsigned}}, b[15:0]} : data;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-outstanding data-bus sequencer with flush draining and
// aligned load writeback.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DST_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  dbus_req_t        in_req,
  input  logic             in_load,
  input  logic             in_unsigned,
  input  logic [DST_W-1:0] in_dst,
  input  logic             cp0_flush,
  output dbus_req_t        dreq,
  input  dbus_resp_t       dresp,
  output logic             stall,
  output logic             wb_valid,
  output logic [31:0]      wb_data,
  output logic [DST_W-1:0] wb_dst
);
  mem_state_t       state;
  dbus_req_t        req_q;
  logic             load_q, uns_q, drop_q;
  logic [DST_W-1:0] dst_q;
  logic             accept, drop, done, load_c, uns_c;
  logic [1:0]       addr_c;
  msize_t           size_c;
  logic [DST_W-1:0] dst_c;
  logic [31:0]      aligned;

  assign accept = state == IDLE && in_req.valid && !cp0_flush && resetn;
  assign drop   = drop_q || cp0_flush;
  // A request seen by the bus is never withdrawn; a flush only marks it for discard.
  assign dreq  = accept ? in_req : state == ADDR ? req_q : '0;
  assign stall = state == IDLE ? accept :
                 state == ADDR ? !(dresp.addr_ok && dresp.data_ok) :
                 state == DATA ? !dresp.data_ok : in_req.valid;
  assign done  = dresp.data_ok && ((accept && dresp.addr_ok) ||
                 (state == ADDR && dresp.addr_ok && !drop) ||
                 (state == DATA && !cp0_flush));

  assign load_c = accept ? in_load : load_q;
  assign uns_c  = accept ? in_unsigned : uns_q;
  assign dst_c  = accept ? in_dst : dst_q;
  assign addr_c = accept ? in_req.addr[1:0] : req_q.addr[1:0];
  assign size_c = accept ? in_req.size : req_q.size;

  load_align u_align (
    .data        (dresp.data),
    .addr        (addr_c),
    .size        (size_c),
    .is_unsigned (uns_c),
    .result      (aligned)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      req_q    <= '0;
      load_q   <= 1'b0;
      uns_q    <= 1'b0;
      dst_q    <= '0;
      drop_q   <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_dst   <= '0;
    end else begin
      wb_valid <= done && load_c;
      if (done && load_c) begin
        wb_data <= aligned;
        wb_dst  <= dst_c;
      end
      case (state)
        IDLE: if (accept) begin
          req_q  <= in_req;
          load_q <= in_load;
          uns_q  <= in_unsigned;
          dst_q  <= in_dst;
          drop_q <= 1'b0;
          state  <= !dresp.addr_ok ? ADDR : dresp.data_ok ? IDLE : DATA;
        end
        ADDR: begin
          drop_q <= drop;
          if (dresp.addr_ok) state <= dresp.data_ok ? IDLE : drop ? DRAIN : DATA;
        end
        DATA: begin
          drop_q <= drop;
          state  <= dresp.data_ok ? IDLE : cp0_flush ? DRAIN : DATA;
        end
        DRAIN: if (dresp.data_ok) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed test-plan cases plus randomized transactions
// checked against a cycle-level behavioural model of the bus handshake.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  dbus_req_t  in_req;
  logic       in_load, in_unsigned, cp0_flush;
  logic [4:0] in_dst;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       stall, wb_valid;
  logic [31:0] wb_data;
  logic [4:0] wb_dst;

  int n_run = 0, n_fail = 0;
  logic [31:0] exp_data = '0;
  logic [4:0]  exp_dst = '0;

  mem_access_unit #(.DST_W(5)) dut (
    .clk(clk), .resetn(resetn), .in_req(in_req), .in_load(in_load),
    .in_unsigned(in_unsigned), .in_dst(in_dst), .cp0_flush(cp0_flush),
    .dreq(dreq), .dresp(dresp), .stall(stall), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_dst(wb_dst)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] a,
                                           input msize_t sz, input bit u);
    longint v;
    int nb, lo;
    if (sz == MSIZE4) return d;
    nb = sz == MSIZE1 ? 1 : 2;
    lo = sz == MSIZE1 ? int'(a) : (int'(a) / 2) * 2;
    v = (longint'(d) >> (8 * lo)) % (longint'(1) << (8 * nb));
    if (!u && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    return v[31:0];
  endfunction

  // Issue at t=0, addr_ok at t=ad, data_ok at t=ad+dd, optional flush at t=tf.
  task automatic run_txn(input dbus_req_t r, input bit ld, input bit uns, input logic [4:0] dst,
                         input logic [31:0] d, input int ad, input int dd,
                         input bit fl, input int tf, input bit offer);
    int td = ad + dd;
    bit in_drain, exp_stall, exp_wb;
    dbus_req_t other;
    other = {1'b0, 32'($urandom), msize_t'($urandom_range(0, 2)), 4'($urandom), 32'($urandom)};
    other.valid = offer;
    for (int t = 0; t <= td; t++) begin
      in_req        = (fl && t >= tf) ? other : r;
      in_load       = ld;
      in_unsigned   = uns;
      in_dst        = dst;
      cp0_flush     = fl && t == tf;
      dresp.addr_ok = t == ad;
      dresp.data_ok = t == td;
      dresp.data    = t == td ? d : 32'($urandom);
      @(negedge clk);
      in_drain  = fl && tf < t && t > ad;
      exp_stall = in_drain ? offer : (t == td ? (t == 0) : 1'b1);
      chk("dreq", dreq, t <= ad ? r : dbus_req_t'('0));
      chk("stall", stall, exp_stall);
      if (t > 0) chk("wb_quiet", wb_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    exp_wb = ld && !fl;
    if (exp_wb) begin
      exp_data = ref_load(d, r.addr[1:0], r.size, uns);
      exp_dst  = dst;
    end
    chk("wb_valid", wb_valid, exp_wb);
    chk("wb_data", wb_data, exp_data);
    chk("wb_dst", wb_dst, exp_dst);
  endtask

  task automatic idle_cycle();
    in_req        = '0;
    cp0_flush     = 1'b0;
    dresp.addr_ok = 1'($urandom);
    dresp.data_ok = 1'($urandom);
    dresp.data    = $urandom;
    @(negedge clk);
    chk("idle_dreq", dreq, dbus_req_t'('0));
    chk("idle_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    chk("idle_wb", wb_valid, 1'b0);
    chk("idle_hold", wb_data, exp_data);
  endtask

  function automatic dbus_req_t mk(input logic [31:0] a, input msize_t sz);
    mk = {1'b1, a, sz, 4'($urandom), 32'($urandom)};
  endfunction

  initial begin
    dbus_req_t r;
    int ad, dd, tf;
    bit fl;
    resetn = 1'b0;
    in_req = '0; in_load = 0; in_unsigned = 0; in_dst = '0; cp0_flush = 0; dresp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dreq", dreq, dbus_req_t'('0));
    chk("rst_stall", stall, 1'b0);
    chk("rst_wb", {wb_valid, wb_data, wb_dst}, 38'h0);
    @(posedge clk);
    #1 resetn = 1'b1;

    run_txn(mk(32'h80000010, MSIZE4), 1, 0, 5'd7, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("lw_data", wb_data, 32'hDEADBEEF);
    run_txn(mk(32'h80000013, MSIZE1), 1, 0, 5'd3, 32'h80123456, 1, 1, 0, 0, 0);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    run_txn(mk(32'h80000013, MSIZE1), 1, 1, 5'd4, 32'h80123456, 0, 2, 0, 0, 0);
    chk("lbu_data", wb_data, 32'h00000080);
    run_txn(mk(32'h80000012, MSIZE2), 1, 0, 5'd5, 32'h80123456, 2, 0, 0, 0, 0);
    chk("lh_data", wb_data, 32'hFFFF8012);
    run_txn(mk(32'h80000020, MSIZE4), 0, 0, 5'd9, 32'h12345678, 3, 1, 0, 0, 0);
    run_txn(mk(32'h80000024, MSIZE4), 1, 0, 5'd10, 32'hCAFEF00D, 0, 4, 1, 1, 0);
    run_txn(mk(32'h80000028, MSIZE4), 1, 0, 5'd11, 32'h0BADF00D, 3, 1, 1, 1, 1);
    run_txn(mk(32'h8000002C, MSIZE2), 1, 1, 5'd12, 32'hA5A55A5A, 1, 0, 0, 0, 0);

    // Asynchronous reset while the access waits for data.
    in_req = mk(32'h80000030, MSIZE4); in_load = 1; in_dst = 5'd13; cp0_flush = 0;
    dresp.addr_ok = 1; dresp.data_ok = 0;
    @(posedge clk);
    #1 in_req = '0; dresp = '0;
    @(negedge clk);
    chk("data_stall", stall, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_dreq", dreq, dbus_req_t'('0));
    chk("arst_stall", stall, 1'b0);
    chk("arst_wb", {wb_valid, wb_data, wb_dst}, 38'h0);
    exp_data = '0;
    exp_dst  = '0;
    @(posedge clk);
    #1 resetn = 1'b1;
    dresp.data_ok = 1; dresp.data = 32'hFFFFFFFF;
    @(posedge clk);
    #1 dresp = '0;
    chk("spurious_wb", wb_valid, 1'b0);
    chk("spurious_data", wb_data, exp_data);

    for (int i = 0; i < 400; i++) begin
      r  = mk($urandom, msize_t'($urandom_range(0, 2)));
      ad = $urandom_range(0, 3);
      dd = $urandom_range(0, 3);
      fl = ($urandom_range(0, 3) == 0) && (ad + dd > 0);
      tf = fl ? $urandom_range(1, ad + dd) : 0;
      run_txn(r, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, ad, dd, fl, tf, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
